// File: rtl/ks_wide_seq_adder.sv
// Multi-cycle WORDS x 32-bit add/subtract built around one time-shared 32-bit
// Kogge-Stone core; one slice per clock, LSB slice first, carry chained between slices.

module ks_adder32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [32:0] o_s,
  output logic [31:0] o_c
);

  logic [5:0][31:0] w_g;
  logic [5:0][31:0] w_p;

  // Parallel-prefix tree: level l combines groups 2^l bits apart.
  always_comb begin
    w_g    = {6{32'd0}};
    w_p    = {6{32'd0}};
    w_g[0] = i_a & i_b;
    w_p[0] = i_a ^ i_b;
    for (int l = 0; l < 5; l++) begin
      w_g[l+1] = w_g[l] | (w_p[l] & (w_g[l] << (1 << l)));
      w_p[l+1] = w_p[l] & ((w_p[l] << (1 << l)) | ((32'd1 << (1 << l)) - 32'd1));
    end
  end

  // o_c[i] is the carry out of bit i with the carry-in folded in as bit -1.
  assign o_c = w_g[5] | (w_p[5] & {32{i_cin}});
  assign o_s = {o_c[31], w_p[0] ^ {o_c[30:0], i_cin}};

endmodule

module ks_wide_seq_adder_chk #(
  parameter int WORDS = 4
) (
  input logic        i_clk,
  input logic        i_rst_n,
  input logic        i_in_ready,
  input logic        i_out_valid,
  input logic        i_out_ready,
  input logic [32*WORDS-1:0] i_sum,
  input logic        i_cout,
  input logic        i_ovf,
  input logic        i_zero,
  input logic [31:0] i_core_a,
  input logic [31:0] i_core_b,
  input logic        i_core_cin,
  input logic [32:0] i_core_s,
  input logic [31:0] i_core_c
);

  // The handshake never offers both directions at once.
  a_hs_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_in_ready && i_out_valid))
    else $error("in_ready and out_valid asserted together");

  // A stalled result is frozen until the consumer takes it.
  a_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_out_valid && !i_out_ready) |=> (i_out_valid && $stable(i_sum) &&
      $stable(i_cout) && $stable(i_ovf) && $stable(i_zero)))
    else $error("result changed under back-pressure");

  // Core sum bits and carry vector must be mutually consistent.
  a_core: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_core_s[31:0] == (i_core_a ^ i_core_b ^ {i_core_c[30:0], i_core_cin})) &&
    (i_core_s[32] == i_core_c[31]))
    else $error("core carry vector inconsistent");

endmodule

module ks_wide_seq_adder #(
  parameter int WORDS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [32*WORDS-1:0]   i_a,
  input  logic [32*WORDS-1:0]   i_b,
  input  logic                  i_cin,
  input  logic                  i_sub,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [32*WORDS-1:0]   o_sum,
  output logic                  o_cout,
  output logic                  o_ovf,
  output logic                  o_zero
);

  localparam int W  = 32 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-33:0]   r_acc;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            r_zero;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [31:0]     w_a_sl;
  logic [31:0]     w_b_sl;
  logic [32:0]     w_s;
  logic [31:0]     w_c;
  logic            w_last;
  logic            w_accept;
  logic            w_zero_final;

  assign w_a_sl       = r_a[{r_idx, 5'd0} +: 32];
  assign w_b_sl       = r_b[{r_idx, 5'd0} +: 32];
  assign w_last       = (r_idx == LAST_IDX);
  assign w_accept     = (r_state == ST_IDLE) && i_in_valid;
  assign w_zero_final = (r_acc == {(W-32){1'b0}}) && (w_s[31:0] == 32'd0);

  ks_adder32 u_core (
    .i_a   (w_a_sl),
    .i_b   (w_b_sl),
    .i_cin (r_carry),
    .o_s   (w_s),
    .o_c   (w_c)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_in_valid) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags registered from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand capture, slice-by-slice accumulation and final result latch.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx   <= {IW{1'b0}};
      r_carry <= 1'b0;
      r_a     <= {W{1'b0}};
      r_b     <= {W{1'b0}};
      r_acc   <= {(W-32){1'b0}};
      r_sum   <= {W{1'b0}};
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub ? 1'b1 : i_cin;
            r_idx   <= {IW{1'b0}};
            r_acc   <= {(W-32){1'b0}};
            r_sum   <= {W{1'b0}};
          end
        end
        ST_RUN: begin
          r_carry <= w_s[32];
          if (w_last) begin
            // Partial slices stay internal; the ports only see the finished word.
            r_idx  <= {IW{1'b0}};
            r_sum  <= {w_s[31:0], r_acc};
            r_cout <= w_s[32];
            r_ovf  <= w_c[30] ^ w_c[31];
            r_zero <= w_zero_final;
          end else begin
            r_idx <= r_idx + {{(IW-1){1'b0}}, 1'b1};
            r_acc[{r_idx, 5'd0} +: 32] <= w_s[31:0];
          end
        end
        ST_DONE: begin
          r_idx <= r_idx;
        end
        default: begin
          r_idx <= {IW{1'b0}};
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;
  assign o_ovf       = r_ovf;
  assign o_zero      = r_zero;

  ks_wide_seq_adder_chk #(.WORDS(WORDS)) u_chk (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_in_ready  (r_in_ready),
    .i_out_valid (r_out_valid),
    .i_out_ready (i_out_ready),
    .i_sum       (r_sum),
    .i_cout      (r_cout),
    .i_ovf       (r_ovf),
    .i_zero      (r_zero),
    .i_core_a    (w_a_sl),
    .i_core_b    (w_b_sl),
    .i_core_cin  (r_carry),
    .i_core_s    (w_s),
    .i_core_c    (w_c)
  );

endmodule

// File: tb/tb_ks_wide_seq_adder.sv
// Directed vector table plus hand sequences for back-pressure and mid-run reset.

module tb_ks_wide_seq_adder;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
    logic         e_zero;
  } vec_t;

  vec_t vecs [9];

  ks_wide_seq_adder #(.WORDS(WORDS)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .i_cin       (cin),
    .i_sub       (sub),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_sum       (sum),
    .o_cout      (cout),
    .o_ovf       (ovf),
    .o_zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand bundle and wait for the result; checks the latency.
  task automatic start_op(input vec_t v);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk_b("in_ready_before_issue", in_ready, 1'b1);
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    cin = v.cin;
    sub = v.sub;
    step();
    in_valid = 1'b0;
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    cin = ~v.cin;
    sub = ~v.sub;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk_w("latency", W'(n), W'(WORDS));
  endtask

  task automatic chk_result(input vec_t v);
    chk_w("sum", sum, v.e_sum);
    chk_b("cout", cout, v.e_cout);
    chk_b("ovf", ovf, v.e_ovf);
    chk_b("zero", zero, v.e_zero);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_b("in_ready_after_consume", in_ready, 1'b1);
    chk_b("out_valid_after_consume", out_valid, 1'b0);
  endtask

  initial begin
    vecs[0] = '{a: {W{1'b1}}, b: 128'd1, cin: 1'b0, sub: 1'b0,
                e_sum: 128'd0, e_cout: 1'b1, e_ovf: 1'b0, e_zero: 1'b1};
    vecs[1] = '{a: 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, b: 128'd1, cin: 1'b0, sub: 1'b0,
                e_sum: 128'h80000000_00000000_00000000_00000000, e_cout: 1'b0, e_ovf: 1'b1, e_zero: 1'b0};
    vecs[2] = '{a: 128'd5, b: 128'd7, cin: 1'b1, sub: 1'b1,
                e_sum: 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, e_cout: 1'b0, e_ovf: 1'b0, e_zero: 1'b0};
    vecs[3] = '{a: 128'h00000000_00000000_00000000_FFFFFFFF, b: 128'd0, cin: 1'b1, sub: 1'b0,
                e_sum: 128'h00000000_00000000_00000001_00000000, e_cout: 1'b0, e_ovf: 1'b0, e_zero: 1'b0};
    vecs[4] = '{a: 128'd3, b: 128'd4, cin: 1'b0, sub: 1'b0,
                e_sum: 128'd7, e_cout: 1'b0, e_ovf: 1'b0, e_zero: 1'b0};
    vecs[5] = '{a: 128'h1234, b: 128'h1234, cin: 1'b0, sub: 1'b1,
                e_sum: 128'd0, e_cout: 1'b1, e_ovf: 1'b0, e_zero: 1'b1};
    vecs[6] = '{a: 128'h80000000_00000000_00000000_00000000, b: 128'h80000000_00000000_00000000_00000000,
                cin: 1'b0, sub: 1'b0, e_sum: 128'd0, e_cout: 1'b1, e_ovf: 1'b1, e_zero: 1'b1};
    vecs[7] = '{a: 128'h80000000_00000000_00000000_00000000, b: 128'd1, cin: 1'b0, sub: 1'b1,
                e_sum: 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, e_cout: 1'b1, e_ovf: 1'b1, e_zero: 1'b0};
    vecs[8] = '{a: 128'h00000001_FFFFFFFF_00000000_FFFFFFFF, b: 128'h00000000_00000001_00000000_00000001,
                cin: 1'b0, sub: 1'b0, e_sum: 128'h00000002_00000000_00000001_00000000,
                e_cout: 1'b0, e_ovf: 1'b0, e_zero: 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    step();
    step();
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_w("rst_sum", sum, '0);
    chk_b("rst_cout", cout, 1'b0);
    chk_b("rst_ovf", ovf, 1'b0);
    chk_b("rst_zero", zero, 1'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i]);
      chk_result(vecs[i]);
      consume();
    end

    // Back-pressure: new operands offered while the result is stalled are ignored.
    start_op(vecs[1]);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a = 128'd3;
      b = 128'd4;
      cin = 1'b0;
      sub = 1'b0;
      step();
      chk_b("bp_out_valid", out_valid, 1'b1);
      chk_b("bp_in_ready", in_ready, 1'b0);
      chk_result(vecs[1]);
    end
    in_valid = 1'b0;
    consume();
    step();
    chk_b("bp_no_accept", in_ready, 1'b1);

    // Consumer already ready before the result appears: one-cycle out_valid.
    out_ready = 1'b1;
    start_op(vecs[8]);
    chk_result(vecs[8]);
    step();
    chk_b("eager_out_valid_drop", out_valid, 1'b0);
    chk_b("eager_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;

    // Reset while slice 2 is pending aborts the transaction.
    in_valid = 1'b1;
    a = {W{1'b1}};
    b = 128'd1;
    cin = 1'b0;
    sub = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_b("mid_rst_in_ready", in_ready, 1'b1);
    chk_b("mid_rst_out_valid", out_valid, 1'b0);
    chk_w("mid_rst_sum", sum, '0);
    chk_b("mid_rst_zero", zero, 1'b0);
    start_op(vecs[4]);
    chk_result(vecs[4]);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
